// File: rtl/fifo_wr_arb_if.sv
// Handshake bundle between two byte requesters, the write arbiter and the shared FIFO.
interface fifo_wr_arb_if #(parameter int DW = 8);
  logic          req0, req1;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1;
  logic          fifo_push;
  logic [DW-1:0] fifo_din;
  logic          fifo_full;
  logic [7:0]    cnt0, cnt1;

  // master: requesters plus FIFO status side; slave: the arbiter
  modport master (output req0, din0, req1, din1, fifo_full,
                  input  gnt0, gnt1, fifo_push, fifo_din, cnt0, cnt1);
  modport slave  (input  req0, din0, req1, din1, fifo_full,
                  output gnt0, gnt1, fifo_push, fifo_din, cnt0, cnt1);
endinterface

// File: rtl/fifo_wr_arb.sv
// Two-requester round-robin write arbiter into a shared FIFO; decision is
// combinational, grant/push/data are registered, at most one push per two cycles.
module fifo_wr_arb #(
  parameter int DW = 8
) (
  input logic         clk,
  input logic         rstn,
  fifo_wr_arb_if.slave bus
);

  logic          rr;
  logic          gnt0_q, gnt1_q, push_q;
  logic [DW-1:0] din_q;
  logic [7:0]    cnt0_q, cnt1_q;
  logic          elig0, elig1, slot_ok, win0, win1;

  // A push cycle blocks the next decision so fifo_full is always current,
  // and a requester is ignored in its own grant cycle since its req/din are stale.
  always_comb begin
    slot_ok = ~bus.fifo_full & ~push_q;
    elig0   = bus.req0 & ~gnt0_q;
    elig1   = bus.req1 & ~gnt1_q;
    win0    = slot_ok & elig0 & (~elig1 | ~rr);
    win1    = slot_ok & elig1 & (~elig0 |  rr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr     <= 1'b0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      push_q <= 1'b0;
      din_q  <= '0;
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      gnt0_q <= win0;
      gnt1_q <= win1;
      push_q <= win0 | win1;
      if (win0) begin
        din_q  <= bus.din0;
        rr     <= 1'b1;
        cnt0_q <= cnt0_q + 8'd1;
      end else if (win1) begin
        din_q  <= bus.din1;
        rr     <= 1'b0;
        cnt1_q <= cnt1_q + 8'd1;
      end
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.fifo_push = push_q;
  assign bus.fifo_din  = din_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed and randomized checks of fifo_wr_arb against a cycle-level reference model.
module tb_fifo_wr_arb;
  localparam int DW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fifo_wr_arb_if #(.DW(DW)) bus ();
  fifo_wr_arb #(.DW(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: what the outputs must show after the most recent edge
  int            m_rr;
  bit            m_gnt0, m_gnt1, m_push;
  logic [DW-1:0] m_din;
  int            m_cnt0, m_cnt1;
  bit            seen0, seen1;   // gnt_i as sampled by the requester at the last edge
  int            npush, ngnt0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".gnt0"}, 32'(bus.gnt0),      32'(m_gnt0));
    chk({tag, ".gnt1"}, 32'(bus.gnt1),      32'(m_gnt1));
    chk({tag, ".push"}, 32'(bus.fifo_push), 32'(m_push));
    chk({tag, ".din"},  32'(bus.fifo_din),  32'(m_din));
    chk({tag, ".cnt0"}, 32'(bus.cnt0),      32'(m_cnt0 % 256));
    chk({tag, ".cnt1"}, 32'(bus.cnt1),      32'(m_cnt1 % 256));
  endtask

  task automatic m_reset();
    m_rr = 0; m_gnt0 = 0; m_gnt1 = 0; m_push = 0; m_din = '0;
    m_cnt0 = 0; m_cnt1 = 0; seen0 = 0; seen1 = 0;
  endtask

  // One clock: decide the winner from the rules, advance the model, check at edge+1.
  task automatic step(input string tag);
    int            w;
    int            cands[$];
    logic [DW-1:0] d0, d1;
    w = -1;
    d0 = bus.din0; d1 = bus.din1;
    if (bus.req0 && !m_gnt0) cands.push_back(0);
    if (bus.req1 && !m_gnt1) cands.push_back(1);
    if (rstn && !bus.fifo_full && !m_push && cands.size() > 0)
      w = (cands.size() == 1) ? cands[0] : m_rr;
    @(posedge clk);
    seen0 = m_gnt0; seen1 = m_gnt1;
    if (!rstn) m_reset();
    else begin
      m_gnt0 = (w == 0);
      m_gnt1 = (w == 1);
      m_push = (w >= 0);
      if (w == 0) begin m_din = d0; m_cnt0++; m_rr = 1; end
      if (w == 1) begin m_din = d1; m_cnt1++; m_rr = 0; end
    end
    #1;
    chk_all(tag);
    if (bus.fifo_push === 1'b1) npush++;
    if (bus.gnt0 === 1'b1) ngnt0++;
  endtask

  task automatic do_reset();
    bus.req0 = 0; bus.req1 = 0; bus.din0 = '0; bus.din1 = '0; bus.fifo_full = 0;
    rstn = 0;
    #1;
    m_reset();
    chk_all("rst_async");
    repeat (2) step("rst_hold");
    rstn = 1;
    #1;
    chk_all("rst_release");
  endtask

  int gseq[$];
  bit prev_push;

  initial begin
    m_reset();
    npush = 0; ngnt0 = 0;
    bus.req0 = 0; bus.req1 = 0; bus.din0 = '0; bus.din1 = '0; bus.fifo_full = 0;
    #6;
    do_reset();

    // single requester
    bus.req0 = 1; bus.din0 = 8'h11;
    step("single_a");
    chk("single.push", 32'(bus.fifo_push), 32'd1);
    chk("single.din",  32'(bus.fifo_din),  32'h11);
    chk("single.cnt0", 32'(bus.cnt0),      32'd1);
    step("single_b");
    chk("single.nopush", 32'(bus.fifo_push), 32'd0);
    bus.req0 = 0;
    step("single_c");

    // contention right after reset: requester 0 first
    do_reset();
    bus.req0 = 1; bus.din0 = 8'h22; bus.req1 = 1; bus.din1 = 8'h33;
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      step("cont");
      if (bus.fifo_push === 1'b1) gseq.push_back(int'(bus.fifo_din));
      if (seen0) bus.req0 = 0;
      if (seen1) bus.req1 = 0;
    end
    chk("cont.n",    32'(gseq.size()), 32'd2);
    if (gseq.size() == 2) begin
      chk("cont.first",  32'(gseq[0]), 32'h22);
      chk("cont.second", 32'(gseq[1]), 32'h33);
    end
    chk("cont.cnt0", 32'(bus.cnt0), 32'd1);
    chk("cont.cnt1", 32'(bus.cnt1), 32'd1);

    // back-pressure: 5 cycles full, then exactly one push of 8'h44
    do_reset();
    bus.fifo_full = 1; bus.req1 = 1; bus.din1 = 8'h44;
    npush = 0;
    for (int i = 0; i < 5; i++) step("full");
    chk("full.nopush", 32'(npush), 32'd0);
    bus.fifo_full = 0;
    step("full_rel");
    chk("full_rel.push", 32'(bus.fifo_push), 32'd1);
    chk("full_rel.gnt1", 32'(bus.gnt1),      32'd1);
    chk("full_rel.din",  32'(bus.fifo_din),  32'h44);
    step("full_post");
    bus.req1 = 0;
    repeat (3) step("full_idle");
    chk("full.once", 32'(npush), 32'd1);

    // continuous dual request, 8 grants, alternating, never back-to-back pushes
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.din0 = 8'hA0; bus.din1 = 8'hB0;
    gseq.delete();
    prev_push = 0;
    for (int i = 0; i < 16; i++) begin
      step("dual");
      chk("dual.b2b", 32'(prev_push & bus.fifo_push), 32'd0);
      prev_push = bus.fifo_push;
      if (bus.gnt0 === 1'b1) gseq.push_back(0);
      if (bus.gnt1 === 1'b1) gseq.push_back(1);
      if (seen0) bus.din0 = bus.din0 + 8'd1;
      if (seen1) bus.din1 = bus.din1 + 8'd1;
    end
    chk("dual.n", 32'(gseq.size()), 32'd8);
    for (int i = 0; i < gseq.size(); i++) chk("dual.seq", 32'(gseq[i]), 32'(i % 2));
    chk("dual.cnt0", 32'(bus.cnt0), 32'd4);
    chk("dual.cnt1", 32'(bus.cnt1), 32'd4);

    // counter wrap: 256 grants to requester 0
    do_reset();
    bus.req0 = 1; bus.din0 = 8'h5A;
    ngnt0 = 0;
    for (int i = 0; i < 512; i++) step("wrap");
    chk("wrap.ngnt", 32'(ngnt0), 32'd256);
    chk("wrap.cnt0", 32'(bus.cnt0), 32'd0);
    chk("wrap.cnt1", 32'(bus.cnt1), 32'd0);
    bus.req0 = 0;
    step("wrap_end");

    // randomized traffic with contract-following requesters and random back-pressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step("rand");
      if (seen0 || !bus.req0) begin
        bus.req0 = ($urandom_range(9) < 7);
        bus.din0 = DW'($urandom);
      end else if ($urandom_range(19) == 0) bus.req0 = 0;
      if (seen1 || !bus.req1) begin
        bus.req1 = ($urandom_range(9) < 7);
        bus.din1 = DW'($urandom);
      end else if ($urandom_range(19) == 0) bus.req1 = 0;
      bus.fifo_full = ($urandom_range(3) == 0);
    end

    // reset asserted during a push cycle
    bus.fifo_full = 0; bus.req1 = 0; bus.req0 = 0;
    repeat (2) step("pre_rst");
    bus.req0 = 1; bus.din0 = 8'h55;
    step("rst_mid_a");
    chk("rst_mid.push_before", 32'(bus.fifo_push), 32'd1);
    #2 rstn = 0;
    #1;
    m_reset();
    chk_all("rst_mid");
    chk("rst_mid.push", 32'(bus.fifo_push), 32'd0);
    chk("rst_mid.cnt0", 32'(bus.cnt0),      32'd0);
    bus.req0 = 0;
    repeat (2) step("rst_mid_hold");
    rstn = 1;
    #1;
    chk_all("rst_mid_release");
    // rr must be back at 0: requester 0 wins contention
    bus.req0 = 1; bus.din0 = 8'h66; bus.req1 = 1; bus.din1 = 8'h77;
    step("rst_mid_rr");
    chk("rst_mid.rr_gnt0", 32'(bus.gnt0),     32'd1);
    chk("rst_mid.rr_din",  32'(bus.fifo_din), 32'h66);
    step("rst_mid_rr2");
    bus.req0 = 0;
    repeat (2) step("rst_mid_rr3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
